// File: rtl/cpu_ctrl_pkg.sv
// Shared state encoding for the CPU execution controller and the display mux that shows state_o.
package cpu_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_STEP = 2'd2;
    localparam state_t ST_HALT = 2'd3;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stability-counter debouncer and rising-edge detector for a raw board button.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic clk_in,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    localparam int unsigned DBW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

    logic           sync_1;
    logic           sync_2;
    logic [DBW-1:0] db_cnt;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            db_cnt <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
            rise   <= 1'b0;
            if (sync_2 == level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                // sync_2 differs from level here, so this is the flip; only a flip to 1 is an event
                level  <= sync_2;
                rise   <= sync_2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Execution controller: issues single-cycle cpu_ce pulses in free-run or single-step mode, with sticky halt.
module cpu_step_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned DIV       = 4,
    parameter int unsigned DB_CYCLES = 16,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic             halt_req,
    output logic             cpu_ce,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int unsigned DIVW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(DIV - 1);
    localparam logic [DIVW-1:0] DIV_PRE  = DIVW'(DIV - 2);

    logic            run_ff;
    logic            run_sw_s;
    logic            step_level;
    logic            step_rise;
    logic            step_evt;
    state_t          state;
    state_t          state_nxt;
    logic [DIVW-1:0] div_cnt;
    logic [DIVW-1:0] div_nxt;
    logic            ce_nxt;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_step_db (
        .clk_in  (clk_in),
        .rst     (rst),
        .btn_raw (step_btn),
        .level   (step_level),
        .rise    (step_rise)
    );

    // rise is only ever asserted alongside a high level; the AND is logically redundant
    assign step_evt = step_rise & step_level;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            run_ff   <= 1'b0;
            run_sw_s <= 1'b0;
        end else begin
            run_ff   <= run_sw;
            run_sw_s <= run_ff;
        end
    end

    // ce_nxt is decided one cycle early so the pulse itself comes straight from a flop
    always_comb begin
        state_nxt = state;
        div_nxt   = div_cnt;
        ce_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (halt_req) begin
                    state_nxt = ST_HALT;
                end else if (run_sw_s) begin
                    state_nxt = ST_RUN;
                end else if (step_evt) begin
                    state_nxt = ST_STEP;
                    ce_nxt    = 1'b1;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_nxt = ST_HALT;
                end else if (!run_sw_s) begin
                    state_nxt = ST_IDLE;
                    div_nxt   = '0;
                end else begin
                    div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
                    ce_nxt  = (div_cnt == DIV_PRE);
                end
            end
            ST_STEP: begin
                state_nxt = halt_req ? ST_HALT : ST_IDLE;
            end
            default: begin
                state_nxt = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            div_cnt   <= '0;
            cpu_ce    <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            state     <= state_nxt;
            div_cnt   <= div_nxt;
            cpu_ce    <= ce_nxt;
            cycle_cnt <= cycle_cnt + CNT_W'(ce_nxt);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Scoreboard bench for cpu_step_ctrl: expected cpu_ce pulses are queued by stimulus and matched by a monitor.
module tb_cpu_step_ctrl;

    typedef struct {
        int          at;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run_sw = 1'b0;
    logic        step_btn = 1'b0;
    logic        halt_req = 1'b0;
    logic        ce0;
    logic [1:0]  st0;
    logic [31:0] cnt0;

    logic        run_sw1 = 1'b0;
    logic        step_btn1 = 1'b0;
    logic        halt_req1 = 1'b0;
    logic        ce1;
    logic [1:0]  st1;
    logic [3:0]  cnt1;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] exp_cnt0 = '0;
    exp_t        e;
    logic        pend0_v = 1'b0;
    logic        pend1_v = 1'b0;
    logic [31:0] pend0;
    logic [31:0] pend1;

    cpu_step_ctrl #(
        .DIV       (4),
        .DB_CYCLES (16),
        .CNT_W     (32)
    ) u0 (
        .clk_in    (clk),
        .rst       (rst),
        .run_sw    (run_sw),
        .step_btn  (step_btn),
        .halt_req  (halt_req),
        .cpu_ce    (ce0),
        .state_o   (st0),
        .cycle_cnt (cnt0)
    );

    cpu_step_ctrl #(
        .DIV       (4),
        .DB_CYCLES (16),
        .CNT_W     (4)
    ) u1 (
        .clk_in    (clk),
        .rst       (rst),
        .run_sw    (run_sw1),
        .step_btn  (step_btn1),
        .halt_req  (halt_req1),
        .cpu_ce    (ce1),
        .state_o   (st1),
        .cycle_cnt (cnt1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse timing is checked on the pulse; the count is checked one cycle later so it is settled.
    always @(negedge clk) begin
        if (pend0_v) begin
            checks++;
            if (cnt0 !== pend0) begin
                errors++;
                $display("FAIL cnt0_after_ce cyc=%0d got=%0d exp=%0d", cyc, cnt0, pend0);
            end
            pend0_v = 1'b0;
        end
        if (pend1_v) begin
            checks++;
            if ({28'd0, cnt1} !== pend1) begin
                errors++;
                $display("FAIL cnt1_after_ce cyc=%0d got=%0d exp=%0d", cyc, cnt1, pend1);
            end
            pend1_v = 1'b0;
        end
        if (ce0) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL stray_ce0 cyc=%0d cnt=%0d", cyc, cnt0);
            end else begin
                e = q0.pop_front();
                if (e.at != cyc) begin
                    errors++;
                    $display("FAIL ce0_time got_cyc=%0d exp_cyc=%0d", cyc, e.at);
                end
                pend0_v = 1'b1;
                pend0   = e.cnt;
            end
        end
        if (ce1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL stray_ce1 cyc=%0d cnt=%0d", cyc, cnt1);
            end else begin
                e = q1.pop_front();
                if (e.at != cyc) begin
                    errors++;
                    $display("FAIL ce1_time got_cyc=%0d exp_cyc=%0d", cyc, e.at);
                end
                pend1_v = 1'b1;
                pend1   = e.cnt;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push0(input int at);
        exp_cnt0 = exp_cnt0 + 1;
        q0.push_back('{at: at, cnt: exp_cnt0});
    endtask

    task automatic push1(input int at, input logic [31:0] cnt);
        q1.push_back('{at: at, cnt: cnt});
    endtask

    initial begin
        int k;
        int l;
        int r;

        repeat (3) @(negedge clk);
        chk("reset_ce", {31'd0, ce0}, 32'd0);
        chk("reset_state", {30'd0, st0}, 32'd0);
        chk("reset_cnt", cnt0, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Free run: first pulse 6 cycles after the switch, then every 4th, 10 pulses in total.
        k = cyc;
        run_sw = 1'b1;
        for (int i = 0; i < 10; i++) push0(k + 6 + 4 * i);
        wait_until(k + 20);
        chk("run_state", {30'd0, st0}, 32'd1);
        wait_until(k + 40);
        run_sw = 1'b0;
        wait_until(k + 42);
        chk("run_last_state", {30'd0, st0}, 32'd1);
        wait_until(k + 43);
        chk("run_exit_idle", {30'd0, st0}, 32'd0);
        wait_until(k + 60);

        // Bouncy step: four 3-cycle toggles, then held high.
        k = cyc;
        step_btn = 1'b1;
        wait_until(k + 3);  step_btn = 1'b0;
        wait_until(k + 6);  step_btn = 1'b1;
        wait_until(k + 9);  step_btn = 1'b0;
        wait_until(k + 12); step_btn = 1'b1;
        l = cyc;
        push0(l + 19);
        wait_until(l + 19);
        chk("step_state", {30'd0, st0}, 32'd2);
        wait_until(l + 20);
        chk("step_back_idle", {30'd0, st0}, 32'd0);
        chk("step_cnt", cnt0, 32'd11);
        wait_until(l + 25);
        step_btn = 1'b0;
        wait_until(l + 60);

        // Halt arriving on the very edge that would issue the third run pulse.
        k = cyc;
        run_sw = 1'b1;
        push0(k + 6);
        push0(k + 10);
        wait_until(k + 13);
        halt_req = 1'b1;
        wait_until(k + 14);
        halt_req = 1'b0;
        chk("halt_state", {30'd0, st0}, 32'd3);
        chk("halt_ce", {31'd0, ce0}, 32'd0);
        step_btn = 1'b1;
        wait_until(k + 44);
        step_btn = 1'b0;
        halt_req = 1'b1;
        wait_until(k + 46);
        halt_req = 1'b0;
        wait_until(k + 80);
        chk("halt_sticky", {30'd0, st0}, 32'd3);
        chk("halt_cnt", cnt0, 32'd13);
        run_sw = 1'b0;
        rst = 1'b1;
        #1;
        chk("halt_rst_state", {30'd0, st0}, 32'd0);
        chk("halt_rst_cnt", cnt0, 32'd0);
        exp_cnt0 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Step event and synced run switch land on the same edge: RUN wins, no step pulse.
        k = cyc;
        step_btn = 1'b1;
        wait_until(k + 16);
        run_sw = 1'b1;
        r = cyc;
        for (int i = 0; i < 5; i++) push0(r + 6 + 4 * i);
        wait_until(r + 3);
        chk("simul_state_run", {30'd0, st0}, 32'd1);
        wait_until(r + 20);
        run_sw = 1'b0;
        wait_until(r + 23);
        chk("simul_idle", {30'd0, st0}, 32'd0);
        chk("simul_cnt", cnt0, 32'd5);
        step_btn = 1'b0;
        wait_until(r + 60);

        // Asynchronous reset while a run pulse is high.
        k = cyc;
        run_sw = 1'b1;
        push0(k + 6);
        wait_until(k + 9);
        @(posedge clk);
        #1;
        chk("pre_rst_ce", {31'd0, ce0}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_ce", {31'd0, ce0}, 32'd0);
        chk("async_rst_state", {30'd0, st0}, 32'd0);
        chk("async_rst_cnt", cnt0, 32'd0);
        run_sw = 1'b0;
        exp_cnt0 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 4-bit counter wraps 15 -> 0 -> 1 over 17 pulses.
        k = cyc;
        run_sw1 = 1'b1;
        for (int i = 0; i < 17; i++) push1(k + 6 + 4 * i, 32'((i + 1) % 16));
        wait_until(k + 70);
        run_sw1 = 1'b0;
        wait_until(k + 90);
        chk("wrap_idle", {30'd0, st1}, 32'd0);
        chk("wrap_cnt", {28'd0, cnt1}, 32'd1);
        chk("u0_idle_during_wrap", cnt0, 32'd0);

        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_step_ctrl.md
Name: cpu_step_ctrl

Overview:
Execution controller downstream of the board clock divider. Runs in the divided-clock domain (`clk_in`) and issues single-cycle clock-enable pulses (`cpu_ce`) to the MIPS datapath. Supports free-run mode, debounced single-step mode and sticky halt, and counts executed CPU cycles for the display.

Parameters:
DIV, 4, run-mode period in `clk_in` cycles between `cpu_ce` pulses (legal 2..255)
DB_CYCLES, 16, consecutive stable cycles before a step-button level change is accepted (legal 2..255)
CNT_W, 32, width of `cycle_cnt`

Ports:
clk_in  input  1  divided system clock; all logic rising-edge
rst  input  1  reset, asynchronous, active-high
run_sw  input  1  free-run switch, asynchronous to `clk_in`
step_btn  input  1  single-step pushbutton, raw and bouncy
halt_req  input  1  synchronous halt request from CPU (e.g. syscall/break decode); sampled only in RUN/IDLE/STEP
cpu_ce  output  1  one-cycle clock enable to CPU registers/PC
state_o  output  2  current FSM state (IDLE=0, RUN=1, STEP=2, HALT=3)
cycle_cnt  output  CNT_W  number of `cpu_ce` pulses issued since reset

Behaviour:
- Reset (async, active-high): state=IDLE, `cpu_ce`=0, `cycle_cnt`=0, `div_cnt`=0. Synchronizer flops are 0, debounced level is 0, and the debounce counter is 0. Reset mid-pulse kills `cpu_ce` immediately.
- Synchronizers: `run_sw` and `step_btn` each pass through 2 flops. `run_sw_s` is the second-flop output. Latency is 2 cycles.
- Debounce:
  - `db_cnt` clears whenever the synced button equals the debounced level.
  - Otherwise `db_cnt` increments. When it reaches DB_CYCLES-1, the debounced level flips and `db_cnt` clears.
  - `step_evt` is a 1-cycle pulse on the 0->1 edge of the debounced level.
  - Minimum press-to-`step_evt` latency is 2+DB_CYCLES cycles. Releases produce no event.
- FSM (registered state; `cpu_ce` decoded registered, i.e. driven on the cycle after the decision):
  - IDLE:
    - `halt_req` -> HALT.
    - Else `run_sw_s`=1 -> RUN.
    - Else `step_evt` -> STEP.
    - Else stay.
  - RUN:
    - `div_cnt` counts 0..DIV-1 and wraps. `cpu_ce`=1 in the cycle `div_cnt`==DIV-1. First pulse occurs DIV cycles after entering RUN.
    - `halt_req` -> HALT. This has priority over everything, and no pulse is issued in that cycle.
    - `run_sw_s`=0 -> IDLE, with `div_cnt` cleared to 0.
    - `step_evt` is ignored.
  - STEP:
    - `cpu_ce`=1 for exactly this one cycle, then IDLE unconditionally.
    - `halt_req` here still yields HALT next cycle. The step pulse is still issued.
  - HALT: `cpu_ce`=0, sticky; only `rst` exits. `step_evt`, `run_sw_s` and `halt_req` are ignored.
- Simultaneous events in IDLE: `run_sw_s`=1 together with `step_evt` -> RUN. The step is discarded.
- `cycle_cnt`: +1 in each cycle `cpu_ce`=1. Unsigned, wraps from 2^CNT_W-1 to 0 without flag.
- `cpu_ce` is never high for 2 consecutive cycles.

Decomposition:
- Shared package `cpu_ctrl_pkg`: state encoding constants (IDLE/RUN/STEP/HALT) and the 2-bit state typedef, reused by the display mux that shows `state_o`.
- One sub-module, `btn_debounce` (params DB_CYCLES; ports `clk_in`, `rst`, `btn_raw`, `level`, `rise`). It contains the synchronizer, the counter and the edge detector, and is reusable for other board buttons.
- `run_sw` synchronizer stays inline.

Test Plan:
- Reset: assert `rst` asynchronously mid-cycle with DIV=4 while in RUN -> `cpu_ce`=0, `state_o`=0 and `cycle_cnt`=0 immediately, without waiting for a clock edge.
- Free run: `run_sw`=1 held 40 cycles (DIV=4) -> first `cpu_ce` at cycle 2+4 after switch, then every 4th cycle. Clearing `run_sw` -> IDLE 2 cycles later and pulses stop.
- Step with bounce: `step_btn` toggles every 3 cycles for 12 cycles, then holds 1 (DB_CYCLES=16) -> exactly one `cpu_ce`, on cycle 2+16+1 after the last toggle. `cycle_cnt`=1 and state returns to IDLE.
- Halt: in RUN, pulse `halt_req` one cycle -> `state_o`=3 next cycle and no further `cpu_ce` despite `run_sw`=1 and step presses; `rst` returns to IDLE.
- Simultaneous: `run_sw_s` rise in the same cycle as `step_evt` -> RUN entered and no STEP pulse. Pulse count matches run-mode timing only.
- Wrap: CNT_W=4, run 16 pulses -> `cycle_cnt` goes 15->0 with no stray `cpu_ce`.
